// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: request, response and ALU-side signals of the ALU request arbiter.
//   req0_*/req1_* : valid/ready operation channels (operands A/B, 2-bit opcode)
//   rsp_*         : single response channel (valid/ready, requester id, result, carry)
//   alu_*         : operands, opcode and enable to the ALU; result and carry/borrow back
//   slave modport : arbiter view; master modport : requester/consumer/ALU view
interface alu_req_arbiter_if;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [1:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [1:0] req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [3:0] rsp_result;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_cont;
    logic       alu_en, alu_carry_borrow;
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready, alu_out, alu_carry_borrow,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry,
        output alu_a, alu_b, alu_cont, alu_en
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready, alu_out, alu_carry_borrow,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry,
        input  alu_a, alu_b, alu_cont, alu_en
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one 4-bit ALU between two requesters (IDLE -> EXEC -> RESP).
//   i_clk       : clock, rising edge
//   i_rst_n     : synchronous active-low reset
//   bus         : alu_req_arbiter_if.slave (request channels, response channel, ALU drive)
//   o_gnt_cnt0/1: saturating per-requester grant counters, CNT_W bits
//   ALU_ARB_RR_EN defined: round-robin tie-break; undefined: requester 0 wins ties.
module alu_req_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_req_arbiter_if.slave bus,
    output logic [CNT_W-1:0] o_gnt_cnt0,
    output logic [CNT_W-1:0] o_gnt_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_a, r_b, r_result;
    logic [1:0]       r_op;
    logic             r_id, r_carry;
    logic [CNT_W-1:0] r_cnt0, r_cnt1;
    logic             w_any, w_pick1, w_accept;

    assign w_any = bus.req0_valid || bus.req1_valid;

`ifdef ALU_ARB_RR_EN
    // r_last holds the requester granted most recently; on a tie the other one wins.
    logic r_last;
    assign w_pick1 = bus.req1_valid && (!bus.req0_valid || !r_last);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_last <= 1'b1;
        else if (w_accept)
            r_last <= w_pick1;
    end
`else
    assign w_pick1 = bus.req1_valid && !bus.req0_valid;
`endif

    // Gated by reset so no READY leaks out while reset is held.
    assign w_accept       = i_rst_n && r_state == IDLE && w_any;
    assign bus.req0_ready = w_accept && !w_pick1;
    assign bus.req1_ready = w_accept && w_pick1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? EXEC : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt0   <= '0;
            r_cnt1   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a  <= w_pick1 ? bus.req1_a : bus.req0_a;
                r_b  <= w_pick1 ? bus.req1_b : bus.req0_b;
                r_op <= w_pick1 ? bus.req1_op : bus.req0_op;
                r_id <= w_pick1;
                if (w_pick1)
                    r_cnt1 <= r_cnt1 + CNT_W'(!(&r_cnt1));
                else
                    r_cnt0 <= r_cnt0 + CNT_W'(!(&r_cnt0));
            end
            if (r_state == EXEC) begin
                r_result <= bus.alu_out;
                // Carry/borrow only has meaning for ADD/SUB.
                r_carry  <= bus.alu_carry_borrow && !r_op[1];
            end
        end
    end

    assign bus.rsp_valid  = r_state == RESP;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_carry  = r_carry;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_cont   = r_op;
    assign bus.alu_en     = r_state == EXEC;
    assign o_gnt_cnt0     = r_cnt0;
    assign o_gnt_cnt1     = r_cnt1;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed bench for alu_req_arbiter with a behavioural ALU alongside.
module tb_alu_req_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cnt0, cnt1;
    logic [1:0] m_cnt0, m_cnt1;
    logic       w;
    int         checks = 0;
    int         errors = 0;

    alu_req_arbiter_if bus();

    alu_req_arbiter #(.CNT_W(2)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus),
        .o_gnt_cnt0(cnt0),
        .o_gnt_cnt1(cnt1)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.alu_out          = 4'h0;
        bus.alu_carry_borrow = 1'b0;
        if (bus.alu_en) begin
            case (bus.alu_cont)
                2'b00: {bus.alu_carry_borrow, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                2'b01: begin
                    bus.alu_out          = bus.alu_a - bus.alu_b;
                    bus.alu_carry_borrow = bus.alu_a < bus.alu_b;
                end
                2'b10: bus.alu_out = bus.alu_a & bus.alu_b;
                default: bus.alu_out = bus.alu_a | bus.alu_b;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    // Full transaction from IDLE with RSP_READY high: grant, EXEC, RESP, back to IDLE.
    task automatic do_op(input logic id, input logic [3:0] res, input logic c);
        #1;
        chk("grant_ready0", bus.req0_ready, !id);
        chk("grant_ready1", bus.req1_ready, id);
        step();
        if (id) m_cnt1 = sat(m_cnt1);
        else m_cnt0 = sat(m_cnt0);
        chk("exec_en", bus.alu_en, 1);
        chk("exec_ready", bus.req0_ready | bus.req1_ready, 0);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("gnt_cnt0", cnt0, m_cnt0);
        chk("gnt_cnt1", cnt1, m_cnt1);
        step();
        chk("resp_valid", bus.rsp_valid, 1);
        chk("resp_en", bus.alu_en, 0);
        chk("resp_id", bus.rsp_id, id);
        chk("resp_result", bus.rsp_result, res);
        chk("resp_carry", bus.rsp_carry, c);
        step();
        chk("idle_rsp_valid", bus.rsp_valid, 0);
    endtask

    initial begin
        m_cnt0 = 2'd0;
        m_cnt1 = 2'd0;
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'h9; bus.req0_b = 4'h8; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h3; bus.req1_b = 4'h5; bus.req1_op = 2'b01;
        step();
        step();
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_carry", bus.rsp_carry, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_cont", bus.alu_cont, 0);
        chk("rst_alu_en", bus.alu_en, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);

        // First grant after reset with both valid goes to requester 0: ADD 9+8 = 1 carry 1.
        rst_n = 1'b1;
        #1;
        chk("first_ready0", bus.req0_ready, 1);
        chk("first_ready1", bus.req1_ready, 0);
        step();
        m_cnt0 = sat(m_cnt0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("add_en", bus.alu_en, 1);
        chk("add_alu_a", bus.alu_a, 4'h9);
        chk("add_alu_b", bus.alu_b, 4'h8);
        chk("add_alu_cont", bus.alu_cont, 2'b00);
        chk("add_cnt0", cnt0, 1);
        step();
        chk("add_rsp_valid", bus.rsp_valid, 1);
        chk("add_en_low", bus.alu_en, 0);
        chk("add_rsp_id", bus.rsp_id, 0);
        chk("add_result", bus.rsp_result, 4'h1);
        chk("add_carry", bus.rsp_carry, 1);
        step();
        chk("add_idle", bus.rsp_valid, 0);

        // Contention: req0 AND C&A = 8, req1 SUB 3-5 = E with borrow.
        bus.req0_valid = 1'b1; bus.req0_a = 4'hC; bus.req0_b = 4'hA; bus.req0_op = 2'b10;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h3; bus.req1_b = 4'h5; bus.req1_op = 2'b01;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            w = (i % 2 == 0);
`else
            w = 1'b0;
`endif
            do_op(w, w ? 4'hE : 4'h8, w);
        end

        // Back-pressure: response held 5 cycles while requester 1 waits.
        bus.req1_valid = 1'b0;
        #1;
        chk("bp_ready0", bus.req0_ready, 1);
        step();
        m_cnt0 = sat(m_cnt0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        step();
        repeat (5) begin
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_id", bus.rsp_id, 0);
            chk("bp_result", bus.rsp_result, 4'h8);
            chk("bp_carry", bus.rsp_carry, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", bus.rsp_valid, 1);
        chk("bp_hs_ready1", bus.req1_ready, 0);
        step();
        chk("bp_after_valid", bus.rsp_valid, 0);
        do_op(1'b1, 4'hE, 1'b1);

        // Reset during EXEC drops the operation.
        #1;
        chk("mid_ready1", bus.req1_ready, 1);
        step();
        chk("mid_exec_en", bus.alu_en, 1);
        rst_n = 1'b0;
        step();
        m_cnt0 = 2'd0;
        m_cnt1 = 2'd0;
        chk("mid_en", bus.alu_en, 0);
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_ready1_rst", bus.req1_ready, 0);
        chk("mid_cnt0", cnt0, 0);
        chk("mid_cnt1", cnt1, 0);
        rst_n = 1'b1;
        do_op(1'b1, 4'hE, 1'b1);

        // Four more grants to requester 1: counter saturates at 3.
        repeat (4) do_op(1'b1, 4'hE, 1'b1);
        chk("sat_cnt1", cnt1, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
